i2s_tx_serializer: RTL and testbench

Downstream stage of the i2s_playback AXI4-Lite register block. It accepts one stereo sample pair per audio frame over a valid/ready handshake and serialises it onto a standard Philips I2S bus. It generates BCLK and LRCK as a clock master from ACLK and inserts silence with an underrun flag when no sample is available at a frame boundary.

---
 rtl/i2s_tx_serializer.sv | 161 ++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one-entry sample buffer, BCLK/LRCK master, silence on underrun.
// Optional saturating underrun counter enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);

    localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
    localparam int unsigned BitW      = $clog2(FrameBits);
    localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BitW-1:0] LastBit = BitW'(FrameBits - 1);
    localparam logic [BitW-1:0] LrckLo  = BitW'(SLOT_WIDTH - 1);
    localparam logic [BitW-1:0] LrckHi  = BitW'(FrameBits - 2);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d, bit_next;
    logic                  bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
    logic                  underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
    logic [SLOT_WIDTH-1:0] slot_l, slot_r;
    logic [FrameBits-1:0]  frame_word;
    logic                  fall, load, accept;

    // Samples sit MSB-aligned in their slots; the frame word is indexed MSB first by bit index.
    assign slot_l     = SLOT_WIDTH'(frm_l_q) << (SLOT_WIDTH - DATA_WIDTH);
    assign slot_r     = SLOT_WIDTH'(frm_r_q) << (SLOT_WIDTH - DATA_WIDTH);
    assign frame_word = {slot_l, slot_r};

    assign bit_next = (bit_q == LastBit) ? '0 : bit_q + 1'b1;
    assign fall     = (state_q == StRun) && enable && bclk_q && (div_q == DivLast);
    assign load     = ((state_q == StIdle) && enable) || (fall && (bit_next == LastBit));
    assign accept   = s_valid && !buf_full_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable)  state_d = StRun;
            StRun:   if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        bclk_d  = bclk_q;
        lrck_d  = lrck_q;
        sdata_d = sdata_q;
        case (state_q)
            StRun: begin
                if (!enable) begin
                    div_d   = '0;
                    bit_d   = '0;
                    bclk_d  = 1'b0;
                    lrck_d  = 1'b0;
                    sdata_d = 1'b0;
                end else if (div_q == DivLast) begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    if (bclk_q) begin
                        // Uses the current frame, so the last slot bit survives the reload edge.
                        bit_d   = bit_next;
                        lrck_d  = (bit_next >= LrckLo) && (bit_next <= LrckHi);
                        sdata_d = frame_word[LastBit - bit_next];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                div_d   = '0;
                bit_d   = enable ? LastBit : '0;
                bclk_d  = 1'b0;
                lrck_d  = 1'b0;
                sdata_d = 1'b0;
            end
        endcase

        buf_l_d    = accept ? s_left : buf_l_q;
        buf_r_d    = accept ? s_right : buf_r_q;
        buf_full_d = accept ? 1'b1 : (load ? 1'b0 : buf_full_q);
        frm_l_d    = load ? (buf_full_q ? buf_l_q : '0) : frm_l_q;
        frm_r_d    = load ? (buf_full_q ? buf_r_q : '0) : frm_r_q;
        underrun_d = load && !buf_full_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            div_q      <= '0;
            bit_q      <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            buf_full_q <= 1'b0;
            frm_l_q    <= '0;
            frm_r_q    <= '0;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            buf_full_q <= buf_full_d;
            frm_l_q    <= frm_l_d;
            frm_r_q    <= frm_r_d;
        end
    end

    assign s_ready   = !buf_full_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrck  = lrck_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET)                              cnt_q <= '0;
        else if (underrun_d && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign underrun_cnt = cnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: captures frames on BCLK rise and compares them with
// frames built from the accepted sample pairs.
module tb_i2s_tx_serializer;

    localparam int unsigned DW = 24;
    localparam int unsigned SW = 32;
    localparam int unsigned CD = 2;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic          s_valid = 1'b0;
    logic          s_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun;
    logic [15:0]   underrun_cnt;

    always #5 ACLK = ~ACLK;

    i2s_tx_serializer #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .CLK_DIV   (CD)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .enable      (enable),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    int tests = 0;
    int fails = 0;

    logic [2*DW-1:0] offer_q[$];
    logic [2*DW-1:0] acc_q[$];
    logic [63:0]     cap_q[$];
    logic [63:0]     caplr_q[$];
    int              sr_at_q[$];
    bit              drv_hold = 1'b0;
    bit              mon_arm = 1'b0;
    int              ur_pulses = 0;
    int              ur_wide = 0;
    int              sr_rise = 0;
    int              bclk_per = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected 64-bit frame as heard by the receiver, first bit in the MSB.
    function automatic logic [63:0] frame_word(input logic [2*DW-1:0] p);
        return (64'(p[2*DW-1:DW]) << (2*SW - DW)) | (64'(p[DW-1:0]) << (SW - DW));
    endfunction

    function automatic logic [63:0] lrck_word();
        logic [63:0] w = '0;
        for (int b = 0; b < 2*SW; b++) w[63-b] = (b >= SW-1) && (b <= 2*SW-2);
        return w;
    endfunction

    function automatic logic [2*DW-1:0] rnd_pair();
        logic [DW-1:0] l = DW'($urandom);
        return {l, ~l};
    endfunction

    // Source: offers queued pairs back to back, records each handshake.
    initial begin
        logic            take;
        logic [2*DW-1:0] cur;
        cur = '0;
        forever begin
            @(negedge ACLK);
            take = !ARESET && s_valid && s_ready;
            if (take) acc_q.push_back(cur);
            @(posedge ACLK);
            #1;
            if (drv_hold) begin
                s_valid = 1'b0;
            end else if (take || !s_valid) begin
                if (offer_q.size() > 0) begin
                    cur     = offer_q.pop_front();
                    s_left  = cur[2*DW-1:DW];
                    s_right = cur[DW-1:0];
                    s_valid = 1'b1;
                end else begin
                    s_valid = 1'b0;
                end
            end
        end
    end

    // Receiver: samples on BCLK rise, aligns on the first low LRCK after arming.
    initial begin
        logic        pb, pu, ps;
        logic [63:0] dw, lw;
        bit          waiting;
        int          cnt, cyc, last_rise;
        pb = 1'b0; pu = 1'b0; ps = 1'b1; dw = '0; lw = '0;
        waiting = 1'b1; cnt = 0; cyc = 0; last_rise = 0;
        forever begin
            @(posedge ACLK);
            #1;
            cyc++;
            if (underrun === 1'b1) begin
                ur_pulses++;
                if (pu) ur_wide++;
            end
            if (s_ready && !ps) sr_rise++;
            if (i2s_bclk && !pb) begin
                bclk_per  = cyc - last_rise;
                last_rise = cyc;
                if (mon_arm) begin
                    if (waiting) begin
                        if (!i2s_lrck) begin
                            waiting = 1'b0;
                            cnt     = 0;
                        end
                    end else begin
                        dw = {dw[62:0], i2s_sdata};
                        lw = {lw[62:0], i2s_lrck};
                        cnt++;
                        if (cnt == 2*SW) begin
                            cap_q.push_back(dw);
                            caplr_q.push_back(lw);
                            sr_at_q.push_back(sr_rise);
                            cnt = 0;
                        end
                    end
                end
            end
            if (!mon_arm) begin
                waiting = 1'b1;
                cnt     = 0;
            end
            pb = i2s_bclk;
            pu = underrun;
            ps = s_ready;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (cap_q.size() < n && k < 6000) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(cap_q.size() >= n), 64'd1);
    endtask

    task automatic wait_sready(input logic v, input string tag);
        int k = 0;
        while (s_ready !== v && k < 2000) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(s_ready), 64'(v));
    endtask

    task automatic chk_frame(input int i, input logic [63:0] exp, input string tag);
        if (cap_q.size() > i) begin
            chk(tag, cap_q[i], exp);
            chk({tag, "_lrck"}, caplr_q[i], lrck_word());
        end else begin
            chk({tag, "_missing"}, 64'(cap_q.size()), 64'(i + 1));
        end
    endtask

    task automatic do_reset();
        drv_hold = 1'b1;
        offer_q.delete();
        tick(2);
        enable  = 1'b0;
        mon_arm = 1'b0;
        ARESET  = 1'b1;
        tick(2);
        ARESET = 1'b0;
        acc_q.delete();
        cap_q.delete();
        caplr_q.delete();
        sr_at_q.delete();
        drv_hold = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [2*DW-1:0] p1, p2, p3;
        logic            bad;
        int              ur0, k;

        // Reset and idle behaviour.
        tick(3);
        chk("rst_sready", 64'(s_ready), 64'd1);
        chk("rst_outputs", 64'({i2s_bclk, i2s_lrck, i2s_sdata, underrun}), 64'd0);
        chk("rst_cnt", 64'(underrun_cnt), 64'd0);
        ARESET = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            bad |= i2s_bclk | i2s_lrck | i2s_sdata | underrun | !s_ready;
        end
        chk("idle_quiet", 64'(bad), 64'd0);
        p1 = {24'hA5A5A5, 24'h123456};
        offer_q.push_back(p1);
        wait_sready(1'b0, "idle_accept");
        chk("idle_after_accept", 64'({i2s_bclk, i2s_lrck, i2s_sdata}), 64'd0);

        // Preloaded pattern followed by a continuous random stream.
        for (int i = 0; i < 9; i++) offer_q.push_back(rnd_pair());
        ur0     = ur_pulses;
        mon_arm = 1'b1;
        enable  = 1'b1;
        tick(1);
        chk("run_entry_lrck", 64'(i2s_lrck), 64'd0);
        wait_frames(9, "stream_frames");
        chk("bclk_period", 64'(bclk_per), 64'(2*CD));
        chk_frame(0, frame_word(p1), "fixed_frame");
        chk("stream_accepted", 64'(acc_q.size()), 64'd10);
        for (int i = 1; i < 9; i++) begin
            if (acc_q.size() > i) chk_frame(i, frame_word(acc_q[i]), $sformatf("stream_f%0d", i));
        end
        chk("stream_no_underrun", 64'(ur_pulses - ur0), 64'd0);
        if (sr_at_q.size() >= 9) chk("sready_pulses", 64'(sr_at_q[8] - sr_at_q[0]), 64'd8);

        // Two pairs then silence.
        do_reset();
        p1 = rnd_pair();
        p2 = rnd_pair();
        offer_q.push_back(p1);
        offer_q.push_back(p2);
        wait_sready(1'b0, "under_preload");
        ur0     = ur_pulses;
        mon_arm = 1'b1;
        enable  = 1'b1;
        wait_frames(4, "under_frames4");
        chk("under_pulses", 64'(ur_pulses - ur0), 64'd3);
        chk("under_cnt", 64'(underrun_cnt), CntEn ? 64'd3 : 64'd0);
        wait_frames(5, "under_frames5");
        chk_frame(0, frame_word(p1), "under_f0");
        chk_frame(1, frame_word(p2), "under_f1");
        for (int i = 2; i < 5; i++) chk_frame(i, 64'd0, $sformatf("under_silent%0d", i));
        chk("under_single_cycle", 64'(ur_wide), 64'd0);

        // Enable dropped in the right slot, then resumed.
        do_reset();
        p1 = rnd_pair();
        p2 = rnd_pair();
        offer_q.push_back(p1);
        offer_q.push_back(p2);
        wait_sready(1'b0, "stop_preload");
        mon_arm = 1'b1;
        enable  = 1'b1;
        k = 0;
        while (i2s_lrck !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
        end
        tick(40);
        chk("stop_mid_right", 64'(i2s_lrck), 64'd1);
        chk("stop_buf_full", 64'(s_ready), 64'd0);
        enable  = 1'b0;
        mon_arm = 1'b0;
        tick(1);
        chk("stop_outputs", 64'({i2s_bclk, i2s_lrck, i2s_sdata}), 64'd0);
        chk("stop_buf_kept", 64'(s_ready), 64'd0);
        tick(20);
        chk("stop_idle", 64'({i2s_bclk, i2s_lrck, i2s_sdata, underrun}), 64'd0);
        cap_q.delete();
        caplr_q.delete();
        mon_arm = 1'b1;
        enable  = 1'b1;
        tick(1);
        chk("resume_lrck", 64'(i2s_lrck), 64'd0);
        wait_frames(1, "resume_frames");
        chk_frame(0, frame_word(p2), "resume_f0");

        // Reset mid-frame with the buffer holding a pair.
        do_reset();
        p1 = rnd_pair();
        p2 = rnd_pair();
        p3 = rnd_pair();
        offer_q.push_back(p1);
        offer_q.push_back(p2);
        wait_sready(1'b0, "rst_preload");
        mon_arm = 1'b1;
        enable  = 1'b1;
        k = 0;
        while ((offer_q.size() > 0 || s_valid) && k < 2000) begin
            tick(1);
            k++;
        end
        tick(2);
        chk("rst_buf_full", 64'(s_ready), 64'd0);
        tick(100);
        ARESET  = 1'b1;
        enable  = 1'b0;
        mon_arm = 1'b0;
        tick(1);
        chk("midrst_sready", 64'(s_ready), 64'd1);
        chk("midrst_outputs", 64'({i2s_bclk, i2s_lrck, i2s_sdata, underrun}), 64'd0);
        chk("midrst_cnt", 64'(underrun_cnt), 64'd0);
        ARESET = 1'b0;
        cap_q.delete();
        caplr_q.delete();
        offer_q.push_back(p3);
        wait_sready(1'b0, "after_rst_preload");
        mon_arm = 1'b1;
        enable  = 1'b1;
        wait_frames(2, "after_rst_frames");
        chk_frame(0, frame_word(p3), "after_rst_f0");
        chk_frame(1, 64'd0, "after_rst_f1");

        enable = 1'b0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
